// File: rtl/ysyx_23060124_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060124_ifu -- instruction fetch unit
//
// Fetches one instruction word at a time over an AXI-lite style read channel.
// It hands the word to the decode stage over a valid/ready link. A fetch
// starts after reset (boot), or when writeback delivers a new PC.
//
// Handshake rule used on every link: a transfer happens on a rising edge
// where both valid and ready are 1. The sender keeps valid and its payload
// stable until that edge. The receiver may drive ready freely.
//
// Ports:
//   clock         rising-edge clock
//   i_rst_n       synchronous, active-low reset
//   i_pc_update   one-cycle pulse from writeback, i_pc_next is valid
//   i_pc_next     next PC to fetch
//   o_araddr      word-aligned fetch address
//   o_arvalid     read address valid
//   i_arready     read address accepted
//   i_rdata       fetched instruction word
//   i_rresp       read response, 2'b00 = OKAY
//   i_rvalid      read data valid
//   o_rready      read data accepted
//   o_ins         instruction to decode
//   o_pc          PC of o_ins
//   o_post_valid  o_ins/o_pc/o_fetch_err valid to decode
//   i_post_ready  decode accepts the instruction
//   o_fetch_err   bus error or misaligned PC, held with o_post_valid
// ----------------------------------------------------------------------------
module ysyx_23060124_ifu #(
    parameter int unsigned                ISA_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0]       RESET_PC  = 32'h8000_0000
) (
    input  logic                 clock,
    input  logic                 i_rst_n,
    input  logic                 i_pc_update,
    input  logic [ISA_WIDTH-1:0] i_pc_next,
    output logic [ISA_WIDTH-1:0] o_araddr,
    output logic                 o_arvalid,
    input  logic                 i_arready,
    input  logic [ISA_WIDTH-1:0] i_rdata,
    input  logic [1:0]           i_rresp,
    input  logic                 i_rvalid,
    output logic                 o_rready,
    output logic [ISA_WIDTH-1:0] o_ins,
    output logic [ISA_WIDTH-1:0] o_pc,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic                 o_fetch_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   boot_q, boot_d;
    logic                   pend_q, pend_d;
    logic [ISA_WIDTH-1:0]   pend_pc_q, pend_pc_d;
    logic [ISA_WIDTH-1:0]   pc_q, pc_d;
    logic [ISA_WIDTH-1:0]   ins_q, ins_d;
    logic                   err_q, err_d;

    always_comb begin
        state_d   = state_q;
        boot_d    = boot_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        err_d     = err_q;

        // A PC pulse that arrives during a fetch is parked. The fetch in
        // flight always runs to completion. A newer pulse replaces the
        // parked one.
        if (state_q != ST_IDLE && i_pc_update) begin
            pend_d    = 1'b1;
            pend_pc_d = i_pc_next;
        end

        case (state_q)
            ST_IDLE: begin
                if (boot_q || pend_q || i_pc_update) begin
                    state_d = ST_AR;
                    // Boot wins. A live pulse beats a parked PC because
                    // the live pulse is newer.
                    if (boot_q)           pc_d = RESET_PC;
                    else if (i_pc_update) pc_d = i_pc_next;
                    else                  pc_d = pend_pc_q;
                    boot_d = 1'b0;
                    pend_d = 1'b0;
                end
            end
            ST_AR: begin
                if (i_arready) state_d = ST_R;
            end
            ST_R: begin
                if (i_rvalid) begin
                    state_d = ST_OUT;
                    ins_d   = i_rdata;
                    err_d   = (i_rresp != 2'b00) || (pc_q[1:0] != 2'b00);
                end
            end
            ST_OUT: begin
                if (i_post_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            boot_q    <= 1'b1;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            pc_q      <= RESET_PC;
            ins_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            boot_q    <= boot_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            pc_q      <= pc_d;
            ins_q     <= ins_d;
            err_q     <= err_d;
        end
    end

    // All outputs come straight from registers. The address drops the low
    // PC bits, so a misaligned PC still fetches the enclosing word.
    assign o_arvalid    = (state_q == ST_AR);
    assign o_rready     = (state_q == ST_R);
    assign o_post_valid = (state_q == ST_OUT);
    assign o_araddr     = {pc_q[ISA_WIDTH-1:2], 2'b00};
    assign o_pc         = pc_q;
    assign o_ins        = ins_q;
    assign o_fetch_err  = err_q;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
module tb_ysyx_23060124_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_pc_update = 1'b0;
    logic [31:0] i_pc_next = '0;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready = 1'b0;
    logic [31:0] i_rdata = '0;
    logic [1:0]  i_rresp = '0;
    logic        i_rvalid = 1'b0;
    logic        o_rready;
    logic [31:0] o_ins;
    logic [31:0] o_pc;
    logic        o_post_valid;
    logic        i_post_ready = 1'b0;
    logic        o_fetch_err;

    always #5 clock = ~clock;

    ysyx_23060124_ifu dut (
        .clock        (clock),
        .i_rst_n      (i_rst_n),
        .i_pc_update  (i_pc_update),
        .i_pc_next    (i_pc_next),
        .o_araddr     (o_araddr),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .o_ins        (o_ins),
        .o_pc         (o_pc),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_fetch_err  (o_fetch_err)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference model: one fetch is in flight from its
    // start until decode accepts it. It goes through three phases: address
    // accepted, data received, then handed to decode.
    logic        m_init = 1'b0;
    logic        m_boot, m_req, m_busy, m_got_addr, m_have_data, m_err;
    logic [31:0] m_req_pc, m_pc, m_ins;
    logic [31:0] exp_q[$];   // fetch addresses the model has issued

    task automatic model_edge();
        if (!i_rst_n) begin
            m_init = 1'b1; m_boot = 1'b1; m_req = 1'b0; m_busy = 1'b0;
            m_got_addr = 1'b0; m_have_data = 1'b0;
            m_pc = RESET_PC; m_ins = '0; m_err = 1'b0; m_req_pc = '0;
            exp_q.delete();
        end else if (m_init) begin
            if (!m_busy) begin
                if (m_boot || m_req || i_pc_update) begin
                    m_pc = m_boot ? RESET_PC : (i_pc_update ? i_pc_next : m_req_pc);
                    m_boot = 1'b0; m_req = 1'b0; m_busy = 1'b1;
                    m_got_addr = 1'b0; m_have_data = 1'b0;
                    exp_q.push_back({m_pc[31:2], 2'b00});
                end
            end else begin
                if (i_pc_update) begin
                    m_req = 1'b1; m_req_pc = i_pc_next;
                end
                if (!m_got_addr) begin
                    if (i_arready) m_got_addr = 1'b1;
                end else if (!m_have_data) begin
                    if (i_rvalid) begin
                        m_have_data = 1'b1;
                        m_ins = i_rdata;
                        m_err = (i_rresp != 2'b00) || (m_pc[1:0] != 2'b00);
                    end
                end else if (i_post_ready) begin
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [2:0] exp_v;
        if (!m_busy)          exp_v = 3'b000;
        else if (m_have_data) exp_v = 3'b100;
        else if (m_got_addr)  exp_v = 3'b010;
        else                  exp_v = 3'b001;
        check_eq("valids", {29'd0, o_post_valid, o_rready, o_arvalid}, {29'd0, exp_v});
        check_eq("pc", o_pc, m_pc);
        check_eq("ins", o_ins, m_ins);
        check_eq("err", {31'd0, o_fetch_err}, {31'd0, m_err});
        if (m_busy && !m_got_addr && exp_q.size() > 0)
            check_eq("araddr", o_araddr, exp_q[$]);
    endtask

    // ---------------- driver ----------------
    // Outputs are checked at the falling edge, then new inputs are applied.
    // The model then advances to match the next rising edge.
    task automatic step(input logic rst_n, input logic arready, input logic rvalid,
                        input logic [31:0] rdata, input logic [1:0] rresp,
                        input logic post_ready, input logic upd, input logic [31:0] pc_next);
        @(negedge clock);
        if (m_init) check_outputs();
        i_rst_n      = rst_n;
        i_arready    = arready;
        i_rvalid     = rvalid;
        i_rdata      = rdata;
        i_rresp      = rresp;
        i_post_ready = post_ready;
        i_pc_update  = upd;
        i_pc_next    = pc_next;
        model_edge();
        @(posedge clock);
    endtask

    task automatic idle();                          step(1, 0, 0, '0, 2'b00, 0, 0, '0); endtask
    task automatic pulse(input logic [31:0] pc);    step(1, 0, 0, '0, 2'b00, 0, 1, pc); endtask
    task automatic ar_ok();                         step(1, 1, 0, '0, 2'b00, 0, 0, '0); endtask
    task automatic r_ok(input logic [31:0] d, input logic [1:0] resp);
        step(1, 0, 1, d, resp, 0, 0, '0);
    endtask
    task automatic accept();                        step(1, 0, 0, '0, 2'b00, 1, 0, '0); endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset and boot fetch
        step(0, 0, 0, '0, 2'b00, 0, 0, '0);
        step(0, 0, 0, '0, 2'b00, 0, 0, '0);
        #1;
        check_eq("rst_pc", o_pc, 32'h8000_0000);
        check_eq("rst_ins", o_ins, 32'h0);
        idle();
        #1;
        check_eq("boot_arvalid", {31'd0, o_arvalid}, 32'd1);
        check_eq("boot_araddr", o_araddr, 32'h8000_0000);
        ar_ok();
        r_ok(32'h0000_0413, 2'b00);
        #1;
        check_eq("boot_post_valid", {31'd0, o_post_valid}, 32'd1);
        check_eq("boot_ins", o_ins, 32'h0000_0413);
        check_eq("boot_pc", o_pc, 32'h8000_0000);
        check_eq("boot_err", {31'd0, o_fetch_err}, 32'd0);
        accept();

        // Backpressure on both the address channel and decode
        pulse(32'h8000_0100);
        #1;
        check_eq("bp_araddr", o_araddr, 32'h8000_0100);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 32'hdead_beef, 2'b00, 1, 0, '0);
        ar_ok();
        r_ok(32'h1234_5678, 2'b00);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 32'hffff_ffff, 2'b11, 0, 0, '0);
        #1;
        check_eq("bp_ins_held", o_ins, 32'h1234_5678);
        accept();

        // A PC update during R is parked and replayed after decode accepts
        pulse(32'h8000_0200);
        ar_ok();
        step(1, 0, 0, '0, 2'b00, 0, 1, 32'h8000_0010);
        r_ok(32'h0000_0013, 2'b00);
        accept();
        idle();
        #1;
        check_eq("early_arvalid", {31'd0, o_arvalid}, 32'd1);
        check_eq("early_araddr", o_araddr, 32'h8000_0010);
        ar_ok(); r_ok(32'h0000_0093, 2'b00); accept();

        // A parked PC and a live pulse in IDLE: the live pulse wins
        pulse(32'h8000_0300);
        step(1, 0, 0, '0, 2'b00, 0, 1, 32'h8000_0020);
        ar_ok(); r_ok(32'h0000_0113, 2'b00); accept();
        pulse(32'h8000_0040);
        #1;
        check_eq("simul_araddr", o_araddr, 32'h8000_0040);
        ar_ok(); r_ok(32'h0000_0193, 2'b00); accept();
        idle();
        #1;
        check_eq("simul_pend_clear", {31'd0, o_arvalid}, 32'd0);

        // Bus error, then misaligned PC
        pulse(32'h8000_0500);
        ar_ok(); r_ok(32'h0000_0213, 2'b10);
        #1;
        check_eq("err_resp", {30'd0, o_post_valid, o_fetch_err}, 32'd3);
        accept();
        pulse(32'h8000_0006);
        #1;
        check_eq("mis_araddr", o_araddr, 32'h8000_0004);
        ar_ok(); r_ok(32'h0000_0293, 2'b00);
        #1;
        check_eq("mis_err", {31'd0, o_fetch_err}, 32'd1);
        check_eq("mis_pc", o_pc, 32'h8000_0006);
        accept();

        // Reset in the middle of R
        pulse(32'h8000_0600);
        ar_ok();
        step(0, 0, 1, 32'h5555_5555, 2'b00, 0, 0, '0);
        #1;
        check_eq("mid_rst_valids", {29'd0, o_post_valid, o_rready, o_arvalid}, 32'd0);
        check_eq("mid_rst_ins", o_ins, 32'h0);
        idle();
        #1;
        check_eq("mid_rst_araddr", o_araddr, 32'h8000_0000);
        ar_ok(); r_ok(32'h0000_0313, 2'b00); accept();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom,
                 ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 6) == 0,
                 $urandom);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_ifu.md
YSYX_23060124_IFU -- requirements
Module: ysyx_23060124_ifu

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h8000_0000, address of the first fetch after reset.
REQ-002 SHALL provide parameter ISA_WIDTH, default 32, width of instruction and PC.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_pc_update  input  1  one-cycle pulse from writeback: next PC valid.
REQ-006 SHALL have port i_pc_next  input  ISA_WIDTH  next PC, sampled when i_pc_update=1.
REQ-007 SHALL have port o_araddr  output  ISA_WIDTH  fetch read address.
REQ-008 SHALL have port o_arvalid  output  1  read address valid.
REQ-009 SHALL have port i_arready  input  1  memory accepts address.
REQ-010 SHALL have port i_rdata  input  ISA_WIDTH  fetched instruction word.
REQ-011 SHALL have port i_rresp  input  2  read response, 2'b00 = OKAY.
REQ-012 SHALL have port i_rvalid  input  1  read data valid.
REQ-013 SHALL have port o_rready  output  1  fetch accepts read data.
REQ-014 SHALL have port o_ins  output  ISA_WIDTH  instruction to decode stage.
REQ-015 SHALL have port o_pc  output  ISA_WIDTH  PC of o_ins.
REQ-016 SHALL have port o_post_valid  output  1  o_ins/o_pc valid to decode.
REQ-017 SHALL have port i_post_ready  input  1  decode accepts instruction.
REQ-018 SHALL have port o_fetch_err  output  1  held with o_post_valid when i_rresp != OKAY or PC misaligned.

Function
REQ-019 SHALL implement FSM states IDLE, AR, R, OUT; exactly one state active.
REQ-020 IDLE: o_arvalid=0, o_rready=0, o_post_valid=0; leaves IDLE for AR when boot flag=1, pending flag=1, or i_pc_update=1.
REQ-021 On IDLE->AR, pc register SHALL load: RESET_PC if boot flag; else i_pc_next if i_pc_update=1 (priority); else pending PC; boot and pending flags clear.
REQ-022 AR: o_arvalid=1, o_araddr={pc[31:2],2'b00}; o_araddr stable while o_arvalid=1; on i_arready=1 -> R same edge.
REQ-023 R: o_rready=1; on i_rvalid=1 capture o_ins<=i_rdata, o_fetch_err<=(i_rresp!=0)|(pc[1:0]!=0), -> OUT.
REQ-024 OUT: o_post_valid=1, o_ins/o_pc/o_fetch_err stable; on i_post_ready=1 -> IDLE; otherwise hold indefinitely.
REQ-025 i_pc_update=1 in AR, R or OUT SHALL set pending flag and store i_pc_next in pending PC; a later pulse overwrites it; no in-flight transaction aborted.
REQ-026 o_pc SHALL equal the pc register, updated only on IDLE->AR.
REQ-027 Minimum latency: IDLE->AR 1 cycle, AR->R 1 cycle with i_arready=1, R->OUT 1 cycle with i_rvalid=1; o_post_valid earliest 3 cycles after trigger.
REQ-028 i_arready/i_rvalid asserted outside AR/R respectively SHALL be ignored.
REQ-029 Registered outputs only; o_arvalid, o_rready, o_post_valid decoded from state register, no combinational path from inputs.

Reset
REQ-030 While i_rst_n=0 at a rising edge: state<=IDLE, boot flag<=1, pending flag<=0, pc<=RESET_PC, o_ins<=0, o_fetch_err<=0.
REQ-031 Reset during AR/R/OUT SHALL abandon the transaction; o_arvalid, o_rready, o_post_valid = 0 the cycle after the reset edge.
REQ-032 First o_arvalid after reset release SHALL occur 1 cycle after the first edge with i_rst_n=1, address RESET_PC.

Verification
REQ-033 Boot: release reset, i_arready=1, i_rvalid=1 next cycle with i_rdata=32'h0000_0413 -> o_araddr=32'h8000_0000, o_post_valid with o_ins=32'h0000_0413, o_pc=32'h8000_0000, o_fetch_err=0.
REQ-034 Backpressure: hold i_arready=0 5 cycles, i_post_ready=0 4 cycles -> o_arvalid and o_araddr stable; o_post_valid, o_ins stable until handshake.
REQ-035 Early update: pulse i_pc_update, i_pc_next=32'h8000_0010 during R -> after decode handshake next fetch address 32'h8000_0010 without further pulse.
REQ-036 Simultaneous: pending=32'h8000_0020 and i_pc_update with 32'h8000_0040 in IDLE -> fetch 32'h8000_0040, pending cleared.
REQ-037 Error: i_rresp=2'b10 -> o_fetch_err=1 with o_post_valid; i_pc_next=32'h8000_0006 -> o_araddr=32'h8000_0004, o_fetch_err=1.
REQ-038 Mid-op reset: assert i_rst_n=0 in R -> next cycle all valids 0, o_ins=0; after release fetch restarts at 32'h8000_0000.
